// File: rtl/fetch_execute_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_execute_queue_pkg
//   Shared types for the fetch -> execute decoupling queue.
//   word_t              : 32-bit machine word
//   fetch_queue_entry_t : one buffered fetch result (pc, instruction, fault)
//   make_entry()        : packs the three fetch fields into one entry
// ---------------------------------------------------------------------------
package fetch_execute_queue_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  fault;
    } fetch_queue_entry_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0000_0200;

    function automatic fetch_queue_entry_t make_entry(word_t pc, word_t instr, logic fault);
        fetch_queue_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/fetch_execute_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_execute_queue_if
//   Bundles the enqueue (fetch side), dequeue (execute side) and redirect
//   signals of the fetch -> execute queue.
//   master : the pipeline stages around the queue (drive enq_*, deq_ready,
//            flush, brj_addr; observe everything else)
//   slave  : the queue itself
//   count is $clog2(DEPTH+1) bits wide so it can represent a full queue.
// ---------------------------------------------------------------------------
interface fetch_execute_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_execute_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             enq_valid;
    logic             enq_ready;
    word_t            enq_pc;
    word_t            enq_instr;
    logic             enq_fault;

    logic             deq_valid;
    logic             deq_ready;
    word_t            deq_pc;
    word_t            deq_instr;
    logic             deq_fault;

    logic             flush;
    word_t            brj_addr;
    logic             redirect_valid;
    word_t            redirect_addr;

    logic [CNT_W-1:0] count;

    modport master (
        output enq_valid, enq_pc, enq_instr, enq_fault,
        output deq_ready, flush, brj_addr,
        input  enq_ready, deq_valid, deq_pc, deq_instr, deq_fault,
        input  redirect_valid, redirect_addr, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, enq_fault,
        input  deq_ready, flush, brj_addr,
        output enq_ready, deq_valid, deq_pc, deq_instr, deq_fault,
        output redirect_valid, redirect_addr, count
    );

endinterface

// File: rtl/fetch_execute_queue_ptr.sv
// ---------------------------------------------------------------------------
// fetch_execute_queue_ptr
//   Read/write pointer and occupancy bookkeeping for a power-of-two circular
//   buffer. Kept free of any payload so other queues can reuse it.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous flush of pointers and count (wins over push/pop)
//   push     : an entry is written at wr_ptr this cycle
//   pop      : the entry at rd_ptr is consumed this cycle
//   rd_ptr, wr_ptr : buffer indices, wrap DEPTH-1 -> 0 by natural overflow
//   count    : occupied entries;  full / empty : decoded from count
// ---------------------------------------------------------------------------
module fetch_execute_queue_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic [$clog2(DEPTH)-1:0]     wr_ptr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pointers advance independently; count only moves when exactly one of
    // push/pop happens, so a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_execute_queue.sv
// ---------------------------------------------------------------------------
// fetch_execute_queue
//   Decouples fetch from execute with a DEPTH-entry circular buffer and
//   valid/ready handshakes on both sides. A flush from execute discards all
//   buffered instructions and returns the branch/jump target to fetch as a
//   registered one-cycle redirect pulse.
//   Parameters : DEPTH (power of two, >= 2), BYPASS (empty-queue pass
//                through), RESET_PC (redirect_addr after reset)
//   clk, rst   : clock and asynchronous active-high reset
//   bus        : fetch_execute_queue_if slave modport
//                enq_* in from fetch, deq_* out to execute, flush/brj_addr
//                in from execute, redirect_* and count out
// ---------------------------------------------------------------------------
module fetch_execute_queue
    import fetch_execute_queue_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter bit    BYPASS   = 1'b1,
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_execute_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;

    logic               enq_ready;
    logic               deq_valid;
    logic               enq_fire;
    logic               deq_fire;
    logic               pass_through;
    logic               push;
    logic               pop;

    fetch_queue_entry_t enq_entry;
    fetch_queue_entry_t head_entry;
    fetch_queue_entry_t mem [DEPTH];

    logic               redirect_valid;
    word_t              redirect_addr;

    fetch_execute_queue_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.flush),
        .push   (push),
        .pop    (pop),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign enq_entry = make_entry(bus.enq_pc, bus.enq_instr, bus.enq_fault);

    // Handshake decode. enq_ready looks only at occupancy and flush, so a
    // full queue stays closed even while execute drains an entry; the slot
    // becomes available on the following cycle. With BYPASS an empty queue
    // shows the incoming instruction directly, and if execute takes it in
    // the same cycle it never touches the buffer.
    always_comb begin
        enq_ready    = 1'b0;
        deq_valid    = 1'b0;
        enq_fire     = 1'b0;
        deq_fire     = 1'b0;
        pass_through = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        head_entry   = mem[rd_ptr];

        enq_ready = !full && !bus.flush;
        if (!bus.flush) begin
            if (!empty) begin
                deq_valid = 1'b1;
            end else if (BYPASS) begin
                deq_valid  = bus.enq_valid;
                head_entry = enq_entry;
            end
        end

        enq_fire     = bus.enq_valid && enq_ready;
        deq_fire     = deq_valid && bus.deq_ready;
        pass_through = BYPASS && empty && enq_fire && deq_fire;
        push         = enq_fire && !pass_through;
        pop          = deq_fire && !empty;
    end

    // Payload storage carries no reset; only pointers and count decide
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enq_entry;
        end
    end

    // Redirect back to fetch: a pulse the cycle after each flush, with the
    // target address held until the next flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_addr  <= RESET_PC;
        end else begin
            redirect_valid <= bus.flush;
            if (bus.flush) begin
                redirect_addr <= bus.brj_addr;
            end
        end
    end

    assign bus.enq_ready      = enq_ready;
    assign bus.deq_valid      = deq_valid;
    assign bus.deq_pc         = head_entry.pc;
    assign bus.deq_instr      = head_entry.instr;
    assign bus.deq_fault      = head_entry.fault;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_addr  = redirect_addr;
    assign bus.count          = count;

endmodule

// File: tb/tb_fetch_execute_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_execute_queue
//   Bench for fetch_execute_queue. Instance A uses BYPASS=1, instance B uses
//   BYPASS=0 and only sees the latency sequence. A scoreboard queue holds
//   the instructions expected at the dequeue side of instance A.
// ---------------------------------------------------------------------------
module tb_fetch_execute_queue;
    import fetch_execute_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_execute_queue_if #(.DEPTH(4)) bus_a ();
    fetch_execute_queue_if #(.DEPTH(4)) bus_b ();

    fetch_execute_queue #(
        .DEPTH    (4),
        .BYPASS   (1'b1),
        .RESET_PC (32'h0000_0200)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    fetch_execute_queue #(
        .DEPTH    (4),
        .BYPASS   (1'b0),
        .RESET_PC (32'h0000_0200)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic       ev;
        word_t      pc;
        logic       dr;
        logic       fl;
        word_t      brj;
        logic [2:0] e_count;
        logic       e_er;
        logic       e_dv;
        word_t      e_pc;
        logic       e_rv;
        word_t      e_ra;
    } vec_t;

    vec_t               tbl [25];
    fetch_queue_entry_t sb [$];
    logic               exp_rv;
    word_t              exp_ra;
    logic               last_enq_fire;
    int                 deq_total;
    int                 n_vec  = 0;
    int                 n_fail = 0;

    function automatic word_t instr_of(word_t pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(logic ev, word_t pc, logic dr, logic fl, word_t brj,
                                logic [2:0] e_count, logic e_er, logic e_dv, word_t e_pc,
                                logic e_rv, word_t e_ra);
        vec_t v;
        v.ev = ev; v.pc = pc; v.dr = dr; v.fl = fl; v.brj = brj;
        v.e_count = e_count; v.e_er = e_er; v.e_dv = e_dv; v.e_pc = e_pc;
        v.e_rv = e_rv; v.e_ra = e_ra;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on instance A at the falling edge and let
    // the combinational outputs settle.
    task automatic applyStimulus(input logic ev, input word_t pc, input logic dr,
                                 input logic fl, input word_t brj);
        @(negedge clk);
        bus_a.enq_valid = ev;
        bus_a.enq_pc    = pc;
        bus_a.enq_instr = instr_of(pc);
        bus_a.enq_fault = pc[2];
        bus_a.deq_ready = dr;
        bus_a.flush     = fl;
        bus_a.brj_addr  = brj;
        #1;
    endtask

    // Compare instance A against the scoreboard model, then advance the
    // model by the handshakes that the coming rising edge will commit.
    task automatic checkOutput();
        int                 size;
        logic               e_er;
        logic               e_dv;
        logic               deq_fire;
        fetch_queue_entry_t head;
        size = sb.size();
        e_er = (size != 4) && !bus_a.flush;
        e_dv = !bus_a.flush && ((size != 0) || bus_a.enq_valid);
        head = (size != 0) ? sb[0] : make_entry(bus_a.enq_pc, bus_a.enq_instr, bus_a.enq_fault);

        check("count",          32'(bus_a.count),      32'(size));
        check("enq_ready",      32'(bus_a.enq_ready),  32'(e_er));
        check("deq_valid",      32'(bus_a.deq_valid),  32'(e_dv));
        check("redirect_valid", 32'(bus_a.redirect_valid), 32'(exp_rv));
        check("redirect_addr",  bus_a.redirect_addr,   exp_ra);
        if (e_dv) begin
            check("deq_pc",    bus_a.deq_pc,            head.pc);
            check("deq_instr", bus_a.deq_instr,         head.instr);
            check("deq_fault", 32'(bus_a.deq_fault),    32'(head.fault));
        end

        last_enq_fire = 1'b0;
        if (bus_a.flush) begin
            sb.delete();
            exp_rv = 1'b1;
            exp_ra = bus_a.brj_addr;
        end else begin
            exp_rv        = 1'b0;
            last_enq_fire = bus_a.enq_valid && e_er;
            deq_fire      = e_dv && bus_a.deq_ready;
            if (deq_fire) begin
                deq_total++;
            end
            if (size == 0 && last_enq_fire && deq_fire) begin
                // passes straight through
            end else begin
                if (deq_fire) begin
                    void'(sb.pop_front());
                end
                if (last_enq_fire) begin
                    sb.push_back(make_entry(bus_a.enq_pc, bus_a.enq_instr, bus_a.enq_fault));
                end
            end
        end
    endtask

    initial begin
        int sent;
        int cycles;

        bus_a.enq_valid = 1'b0; bus_a.enq_pc = '0; bus_a.enq_instr = '0; bus_a.enq_fault = 1'b0;
        bus_a.deq_ready = 1'b0; bus_a.flush = 1'b0; bus_a.brj_addr = '0;
        bus_b.enq_valid = 1'b0; bus_b.enq_pc = '0; bus_b.enq_instr = '0; bus_b.enq_fault = 1'b0;
        bus_b.deq_ready = 1'b0; bus_b.flush = 1'b0; bus_b.brj_addr = '0;
        exp_rv    = 1'b0;
        exp_ra    = 32'h0000_0200;
        deq_total = 0;

        //            ev   pc           dr   fl   brj          cnt er   dv   deq_pc       rv   ra
        tbl[0]  = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200);
        tbl[1]  = mk(1'b1, 32'h204, 1'b0, 1'b0, 32'h0,   3'd1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200);
        tbl[2]  = mk(1'b1, 32'h208, 1'b0, 1'b0, 32'h0,   3'd2, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200);
        tbl[3]  = mk(1'b1, 32'h20C, 1'b0, 1'b0, 32'h0,   3'd3, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200);
        tbl[4]  = mk(1'b1, 32'h210, 1'b0, 1'b0, 32'h0,   3'd4, 1'b0, 1'b1, 32'h200, 1'b0, 32'h200);
        tbl[5]  = mk(1'b1, 32'h210, 1'b1, 1'b0, 32'h0,   3'd4, 1'b0, 1'b1, 32'h200, 1'b0, 32'h200);
        tbl[6]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd3, 1'b1, 1'b1, 32'h204, 1'b0, 32'h200);
        tbl[7]  = mk(1'b1, 32'h214, 1'b0, 1'b1, 32'h400, 3'd3, 1'b0, 1'b0, 32'h0,   1'b0, 32'h200);
        tbl[8]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h400);
        tbl[9]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h400);
        tbl[10] = mk(1'b1, 32'h300, 1'b1, 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h400);
        tbl[11] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h400);
        tbl[12] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400);
        tbl[13] = mk(1'b1, 32'h204, 1'b0, 1'b0, 32'h0,   3'd1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400);
        tbl[14] = mk(1'b1, 32'h208, 1'b0, 1'b0, 32'h0,   3'd2, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400);
        tbl[15] = mk(1'b1, 32'h20C, 1'b0, 1'b0, 32'h0,   3'd3, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400);
        tbl[16] = mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   3'd4, 1'b0, 1'b1, 32'h200, 1'b0, 32'h400);
        tbl[17] = mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   3'd3, 1'b1, 1'b1, 32'h204, 1'b0, 32'h400);
        tbl[18] = mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   3'd2, 1'b1, 1'b1, 32'h208, 1'b0, 32'h400);
        tbl[19] = mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   3'd1, 1'b1, 1'b1, 32'h20C, 1'b0, 32'h400);
        tbl[20] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h400);
        tbl[21] = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h500, 3'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h400);
        tbl[22] = mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h600, 3'd0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h500);
        tbl[23] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h600);
        tbl[24] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h600);

        // Reset held for three cycles, outputs inspected while still in reset.
        repeat (3) @(posedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("reset_count_b", 32'(bus_b.count),     32'd0);
        check("reset_er_b",    32'(bus_b.enq_ready), 32'd1);
        checkOutput();
        rst = 1'b0;

        $display("[TB] table sequence");
        for (int i = 0; i < 25; i++) begin
            applyStimulus(tbl[i].ev, tbl[i].pc, tbl[i].dr, tbl[i].fl, tbl[i].brj);
            check($sformatf("tbl%0d_count", i),     32'(bus_a.count),          32'(tbl[i].e_count));
            check($sformatf("tbl%0d_enq_ready", i), 32'(bus_a.enq_ready),      32'(tbl[i].e_er));
            check($sformatf("tbl%0d_deq_valid", i), 32'(bus_a.deq_valid),      32'(tbl[i].e_dv));
            check($sformatf("tbl%0d_rv", i),        32'(bus_a.redirect_valid), 32'(tbl[i].e_rv));
            check($sformatf("tbl%0d_ra", i),        bus_a.redirect_addr,       tbl[i].e_ra);
            if (tbl[i].e_dv) begin
                check($sformatf("tbl%0d_deq_pc", i), bus_a.deq_pc, tbl[i].e_pc);
            end
            checkOutput();
        end

        $display("[TB] random wrap sequence");
        sent      = 0;
        cycles    = 0;
        deq_total = 0;
        while ((sent < 10 || sb.size() != 0) && cycles < 300) begin
            applyStimulus(sent < 10, 32'h1000 + 32'(sent) * 4, 1'($urandom_range(0, 1)),
                          1'b0, 32'h0);
            checkOutput();
            if (last_enq_fire) begin
                sent++;
            end
            cycles++;
        end
        check("wrap_sent",      32'(sent),      32'd10);
        check("wrap_delivered", 32'(deq_total), 32'd10);
        check("wrap_left",      32'(sb.size()), 32'd0);

        $display("[TB] no-bypass latency sequence");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput();
        @(negedge clk);
        bus_b.enq_valid = 1'b1; bus_b.enq_pc = 32'h300; bus_b.enq_instr = instr_of(32'h300);
        bus_b.enq_fault = 1'b0; bus_b.deq_ready = 1'b1;
        #1;
        check("nobyp_dv0",    32'(bus_b.deq_valid), 32'd0);
        check("nobyp_er0",    32'(bus_b.enq_ready), 32'd1);
        check("nobyp_count0", 32'(bus_b.count),     32'd0);
        @(negedge clk);
        bus_b.enq_valid = 1'b0;
        #1;
        check("nobyp_dv1",    32'(bus_b.deq_valid), 32'd1);
        check("nobyp_pc1",    bus_b.deq_pc,         32'h300);
        check("nobyp_instr1", bus_b.deq_instr,      instr_of(32'h300));
        check("nobyp_count1", 32'(bus_b.count),     32'd1);
        @(negedge clk);
        bus_b.deq_ready = 1'b0;
        #1;
        check("nobyp_dv2",    32'(bus_b.deq_valid), 32'd0);
        check("nobyp_count2", 32'(bus_b.count),     32'd0);

        $display("[TB] reset during operation");
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
        checkOutput();
        applyStimulus(1'b1, 32'h704, 1'b0, 1'b0, 32'h0);
        checkOutput();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("pre_rst_count", 32'(bus_a.count), 32'd2);
        rst = 1'b1;
        #1;
        sb.delete();
        exp_rv = 1'b0;
        exp_ra = 32'h0000_0200;
        check("rst_count",     32'(bus_a.count),          32'd0);
        check("rst_deq_valid", 32'(bus_a.deq_valid),      32'd0);
        check("rst_enq_ready", 32'(bus_a.enq_ready),      32'd1);
        check("rst_ra",        bus_a.redirect_addr,       32'h0000_0200);
        check("rst_rv",        32'(bus_a.redirect_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
        checkOutput();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
